data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 188 ++++++++++++++++++
 tb/tb_data_memory.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Byte-addressable data memory for a small core: block-RAM data region plus an
// MMIO window with a free-running cycle counter, a TX byte FIFO and sticky error flags.
module data_memory #(
    parameter int DEPTH_WORDS = 1024,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_rd_addr,
    output logic [31:0] data_rd_data,
    input  logic [1:0]  data_wr,
    input  logic [31:0] data_wr_addr,
    input  logic [31:0] data_wr_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [27:0] MMIO_PAGE = 28'hFFFF000;

    typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_MMIO} rd_src_t;

    // ---------------- address decode ----------------
    logic          rd_is_ram, rd_is_mmio, wr_is_ram, wr_is_mmio;
    logic [AW-1:0] rd_idx, wr_idx;
    logic          rd_lsb_unused;

    assign rd_is_ram     = (data_rd_addr[31:AW+2] == '0);
    assign rd_is_mmio    = (data_rd_addr[31:4] == MMIO_PAGE);
    assign wr_is_ram     = (data_wr_addr[31:AW+2] == '0);
    assign wr_is_mmio    = (data_wr_addr[31:4] == MMIO_PAGE);
    assign rd_idx        = data_rd_addr[AW+1:2];
    assign wr_idx        = data_wr_addr[AW+1:2];
    assign rd_lsb_unused = ^data_rd_addr[1:0];

    // ---------------- RAM write lanes ----------------
    logic        wr_aligned;
    logic [3:0]  wr_be;
    logic [31:0] wr_word;

    always_comb begin
        wr_aligned = 1'b1;
        case (data_wr)
            2'b10:   wr_aligned = ~data_wr_addr[0];
            2'b11:   wr_aligned = (data_wr_addr[1:0] == 2'b00);
            default: wr_aligned = 1'b1;
        endcase
    end

    // Operand is replicated across lanes so each lane just picks its own byte.
    always_comb begin
        wr_be   = 4'b0000;
        wr_word = '0;
        if (wr_is_ram && wr_aligned && !rst) begin
            case (data_wr)
                2'b01: begin
                    wr_be   = 4'b0001 << data_wr_addr[1:0];
                    wr_word = {4{data_wr_data[7:0]}};
                end
                2'b10: begin
                    wr_be   = data_wr_addr[1] ? 4'b1100 : 4'b0011;
                    wr_word = {2{data_wr_data[15:0]}};
                end
                2'b11: begin
                    wr_be   = 4'b1111;
                    wr_word = data_wr_data;
                end
                default: ;
            endcase
        end
    end

    // Same-word write data is captured beside the RAM output and merged after the
    // edge, so the array itself stays a plain read-first block RAM per lane.
    logic [3:0]  byp_be_reg;
    logic [31:0] byp_word_reg;
    logic [31:0] ram_merged;

    always_ff @(posedge clk) begin
        byp_be_reg   <= (rd_is_ram && (rd_idx == wr_idx)) ? wr_be : 4'b0000;
        byp_word_reg <= wr_word;
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] q_reg;

            always_ff @(posedge clk) begin
                if (wr_be[gi]) begin
                    mem[wr_idx] <= wr_word[8*gi +: 8];
                end
                q_reg <= mem[rd_idx];
            end

            assign ram_merged[8*gi +: 8] = byp_be_reg[gi] ? byp_word_reg[8*gi +: 8] : q_reg;
        end
    endgenerate

    // ---------------- MMIO write decode ----------------
    logic mmio_wr, push_req, clr_req, align_set;

    assign mmio_wr   = (data_wr != 2'b00) && wr_is_mmio;
    assign push_req  = mmio_wr && (data_wr_addr[3:2] == 2'd1);
    assign clr_req   = mmio_wr && (data_wr_addr[3:2] == 2'd2);
    assign align_set = (data_wr != 2'b00) && wr_is_ram && !wr_aligned;

    // ---------------- TX FIFO ----------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          full, empty, pop, push, ovf_set;

    assign full    = (count_reg == CW'(FIFO_DEPTH));
    assign empty   = (count_reg == '0);
    assign pop     = !empty && tx_ready;
    assign push    = push_req && (!full || pop);
    assign ovf_set = push_req && full && !pop;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= data_wr_data[7:0];
        end
    end

    assign tx_valid = !empty;
    assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr_reg];

    // ---------------- control state ----------------
    logic [31:0] cycle_reg;
    logic        err_align_reg, err_ovf_reg;
    logic [31:0] status_word, mmio_rd_next, mmio_rd_reg;
    rd_src_t     rd_src_reg;

    assign status_word = {24'd0, 4'(count_reg), err_ovf_reg, err_align_reg, empty, full};

    always_comb begin
        mmio_rd_next = '0;
        case (data_rd_addr[3:2])
            2'd0:    mmio_rd_next = cycle_reg;
            2'd2:    mmio_rd_next = status_word;
            default: mmio_rd_next = '0;
        endcase
    end

    // Error set terms are OR-ed after the clear so a coincident set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_reg     <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            err_align_reg <= 1'b0;
            err_ovf_reg   <= 1'b0;
            mmio_rd_reg   <= '0;
            rd_src_reg    <= SRC_ZERO;
        end else begin
            cycle_reg     <= cycle_reg + 32'd1;
            count_reg     <= count_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            err_align_reg <= align_set | (err_align_reg & ~(clr_req & data_wr_data[2]));
            err_ovf_reg   <= ovf_set   | (err_ovf_reg   & ~(clr_req & data_wr_data[3]));
            mmio_rd_reg   <= mmio_rd_next;
            rd_src_reg    <= rd_is_ram ? SRC_RAM : (rd_is_mmio ? SRC_MMIO : SRC_ZERO);
        end
    end

    always_comb begin
        data_rd_data = '0;
        case (rd_src_reg)
            SRC_RAM:  data_rd_data = ram_merged;
            SRC_MMIO: data_rd_data = mmio_rd_reg;
            default:  data_rd_data = '0;
        endcase
    end
endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed vector table, FIFO/reset sequences
// and randomized traffic against a byte-array / queue reference model.
module tb_data_memory;
    localparam int DW = 64;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_rd_addr;
    logic [31:0] data_rd_data;
    logic [1:0]  data_wr;
    logic [31:0] data_wr_addr;
    logic [31:0] data_wr_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    always #5 clk = ~clk;

    data_memory #(.DEPTH_WORDS(DW), .FIFO_DEPTH(FD)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_rd_addr (data_rd_addr),
        .data_rd_data (data_rd_data),
        .data_wr      (data_wr),
        .data_wr_addr (data_wr_addr),
        .data_wr_data (data_wr_data),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  m_ram [4*DW];
    logic [7:0]  m_fifo [$];
    bit          m_align, m_ovf;
    logic [31:0] m_cycle;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit is_ram(input logic [31:0] a);
        return a < 32'(4*DW);
    endfunction

    function automatic bit is_mmio(input logic [31:0] a);
        return (a >= 32'hFFFF0000) && (a <= 32'hFFFF000F);
    endfunction

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        int b = int'(a) & ~3;
        return {m_ram[b+3], m_ram[b+2], m_ram[b+1], m_ram[b]};
    endfunction

    // One clock of the model; returns what data_rd_data must show after this edge.
    task automatic model_step(input logic [31:0] ra, input logic [1:0] ws, input logic [31:0] wa,
                              input logic [31:0] wd, input logic rdy, output logic [31:0] exp);
        int          n;
        bit          set_align = 0, set_ovf = 0, push_req, clr;
        logic [31:0] status_pre;
        logic [3:0]  occ;
        occ        = 4'(m_fifo.size());
        status_pre = {24'd0, occ, m_ovf, m_align, m_fifo.size() == 0, m_fifo.size() == FD};
        exp = 32'd0;
        if (is_mmio(ra)) begin
            if (ra[3:2] == 2'd0) exp = m_cycle;
            else if (ra[3:2] == 2'd2) exp = status_pre;
        end
        if (ws != 2'd0 && is_ram(wa)) begin
            if ((ws == 2'd2 && wa[0]) || (ws == 2'd3 && wa[1:0] != 2'b00)) begin
                set_align = 1;
            end else begin
                n = (ws == 2'd1) ? 1 : (ws == 2'd2) ? 2 : 4;
                for (int i = 0; i < n; i++) m_ram[int'(wa) + i] = wd[8*i +: 8];
            end
        end
        if (is_ram(ra)) exp = ram_word(ra);
        push_req = (ws != 2'd0) && is_mmio(wa) && (wa[3:2] == 2'd1);
        clr      = (ws != 2'd0) && is_mmio(wa) && (wa[3:2] == 2'd2);
        if (rdy && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (push_req) begin
            if (m_fifo.size() < FD) m_fifo.push_back(wd[7:0]);
            else set_ovf = 1;
        end
        m_align = set_align | (m_align & !(clr & wd[2]));
        m_ovf   = set_ovf   | (m_ovf   & !(clr & wd[3]));
        m_cycle = m_cycle + 32'd1;
    endtask

    // Called at posedge+1; leaves at the following posedge+1.
    task automatic do_cycle(input logic [31:0] ra, input logic [1:0] ws, input logic [31:0] wa,
                            input logic [31:0] wd, input logic rdy, output logic [31:0] got);
        logic [31:0] exp;
        logic [31:0] exp_tx;
        data_rd_addr = ra;
        data_wr      = ws;
        data_wr_addr = wa;
        data_wr_data = wd;
        tx_ready     = rdy;
        #1;
        exp_tx = 32'd0;
        if (m_fifo.size() > 0) exp_tx = 32'(m_fifo[0]);
        check("tx_valid", 32'(tx_valid), 32'(m_fifo.size() > 0));
        check("tx_data", 32'(tx_data), exp_tx);
        model_step(ra, ws, wa, wd, rdy, exp);
        @(posedge clk);
        #1;
        got = data_rd_data;
        check("rd_data", got, exp);
        $display("txn ra=%08h ws=%0d wa=%08h wd=%08h rdy=%0b rd=%08h", ra, ws, wa, wd, rdy, got);
    endtask

    typedef struct packed {
        logic [31:0] ra;
        logic [1:0]  ws;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [16];

    function automatic logic [31:0] rand_addr();
        int sel = $urandom_range(0, 9);
        if (sel < 7) return 32'($urandom_range(0, 4*DW - 1));
        if (sel < 9) return 32'hFFFF0000 + 32'(4 * $urandom_range(0, 3));
        return $urandom & 32'h7FFF_FFFF;
    endfunction

    initial begin
        logic [31:0] got;

        vecs[0]  = '{32'h10,       2'd3, 32'h10,       32'h11223344, 32'h11223344};
        vecs[1]  = '{32'h10,       2'd1, 32'h11,       32'h000000AA, 32'h1122AA44};
        vecs[2]  = '{32'h10,       2'd0, 32'h0,        32'h0,        32'h1122AA44};
        vecs[3]  = '{32'h20,       2'd2, 32'h22,       32'h0000BEEF, 32'hBEEF0000};
        vecs[4]  = '{32'h20,       2'd2, 32'h21,       32'h00001234, 32'hBEEF0000};
        vecs[5]  = '{32'hFFFF0008, 2'd0, 32'h0,        32'h0,        32'h00000006};
        vecs[6]  = '{32'hFFFF0008, 2'd3, 32'hFFFF0008, 32'h00000004, 32'h00000006};
        vecs[7]  = '{32'hFFFF0008, 2'd0, 32'h0,        32'h0,        32'h00000002};
        vecs[8]  = '{32'h10000000, 2'd3, 32'h10000000, 32'h0000DEAD, 32'h00000000};
        vecs[9]  = '{32'hFFFF000C, 2'd3, 32'hFFFF000C, 32'h12345678, 32'h00000000};
        vecs[10] = '{32'hFFFF0004, 2'd0, 32'h0,        32'h0,        32'h00000000};
        vecs[11] = '{32'hFC,       2'd3, 32'hFC,       32'hCAFEF00D, 32'hCAFEF00D};
        vecs[12] = '{32'h100,      2'd3, 32'h100,      32'h00005555, 32'h00000000};
        vecs[13] = '{32'h0,        2'd0, 32'h0,        32'h0,        32'h00000000};
        vecs[14] = '{32'h20,       2'd2, 32'h20,       32'hFFFFBEEF, 32'hBEEFBEEF};
        vecs[15] = '{32'h10,       2'd1, 32'h13,       32'h00000077, 32'h7722AA44};

        rst = 1'b1;
        data_rd_addr = '0; data_wr = '0; data_wr_addr = '0; data_wr_data = '0; tx_ready = 1'b0;
        m_fifo.delete(); m_align = 0; m_ovf = 0; m_cycle = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_data", data_rd_data, 32'd0);
        check("reset_tx_valid", 32'(tx_valid), 32'd0);
        check("reset_tx_data", 32'(tx_data), 32'd0);
        rst = 1'b0;

        // Known RAM contents for the model
        for (int w = 0; w < DW; w++) do_cycle(32'd0, 2'd3, 32'(4*w), 32'd0, 1'b0, got);

        for (int i = 0; i < 16; i++) begin
            do_cycle(vecs[i].ra, vecs[i].ws, vecs[i].wa, vecs[i].wd, 1'b1, got);
            check($sformatf("vec%0d", i), got, vecs[i].exp);
        end

        // Overflow: five pushes into a four-deep FIFO with the consumer stalled
        for (int b = 8'h41; b <= 8'h45; b++) do_cycle(32'd0, 2'd1, 32'hFFFF0004, 32'(b), 1'b0, got);
        do_cycle(32'hFFFF0008, 2'd0, 32'd0, 32'd0, 1'b0, got);
        check("status_full_ovf", got, 32'h49);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain%0d", k), 32'(tx_data), 32'h41 + 32'(k));
            do_cycle(32'd0, 2'd0, 32'd0, 32'd0, 1'b1, got);
        end
        check("drained_valid", 32'(tx_valid), 32'd0);
        do_cycle(32'hFFFF0008, 2'd3, 32'hFFFF0008, 32'h8, 1'b0, got);
        check("status_empty_ovf", got, 32'h0A);
        do_cycle(32'hFFFF0008, 2'd0, 32'd0, 32'd0, 1'b0, got);
        check("status_ovf_clr", got, 32'h02);

        // Push into a full FIFO while popping is accepted
        for (int b = 8'h60; b <= 8'h63; b++) do_cycle(32'd0, 2'd1, 32'hFFFF0004, 32'(b), 1'b0, got);
        check("full_head", 32'(tx_data), 32'h60);
        do_cycle(32'd0, 2'd1, 32'hFFFF0004, 32'h50, 1'b1, got);
        do_cycle(32'hFFFF0008, 2'd0, 32'd0, 32'd0, 1'b0, got);
        check("status_push_pop_full", got, 32'h41);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("pp_drain%0d", k), 32'(tx_data), (k == 3) ? 32'h50 : 32'h61 + 32'(k));
            do_cycle(32'd0, 2'd0, 32'd0, 32'd0, 1'b1, got);
        end

        // Reset mid-drain, with write attempts while held in reset
        for (int b = 0; b < 3; b++) do_cycle(32'd0, 2'd1, 32'hFFFF0004, 32'h70 + 32'(b), 1'b0, got);
        do_cycle(32'h10, 2'd0, 32'd0, 32'd0, 1'b1, got);
        #2;
        rst = 1'b1;
        data_wr = 2'd3; data_wr_addr = 32'h30; data_wr_data = 32'hDEADBEEF;
        #1;
        check("async_tx_valid", 32'(tx_valid), 32'd0);
        check("async_tx_data", 32'(tx_data), 32'd0);
        check("async_rd_data", data_rd_data, 32'd0);
        m_fifo.delete(); m_align = 0; m_ovf = 0; m_cycle = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) do_cycle(32'd0, 2'd0, 32'd0, 32'd0, 1'b0, got);
        do_cycle(32'hFFFF0000, 2'd0, 32'd0, 32'd0, 1'b0, got);
        check("cycle_after_reset", got, 32'd5);
        do_cycle(32'h30, 2'd0, 32'd0, 32'd0, 1'b0, got);
        check("ram_write_in_reset", got, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            do_cycle(rand_addr(), 2'($urandom_range(0, 3)), rand_addr(), $urandom,
                     1'($urandom_range(0, 1)), got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
